// File: rtl/prbs_pkg.sv
`timescale 1ns/1ps
// Shared polynomial constants and state types for the PRBS generator/checker.
// Polynomials are x^N + x^T + 1 with the (N, T) pairs below.
package prbs_pkg;

    localparam int PRBS_MAX_N = 31;
    localparam logic [PRBS_MAX_N-1:0] DEFAULT_SEED = 31'h7FFF_FFFF;

    localparam int N_PRBS7  = 7;
    localparam int N_PRBS15 = 15;
    localparam int N_PRBS23 = 23;
    localparam int N_PRBS31 = 31;
    localparam int T_PRBS7  = 6;
    localparam int T_PRBS15 = 14;
    localparam int T_PRBS23 = 18;
    localparam int T_PRBS31 = 28;

    typedef enum logic [1:0] {
        PRBS7  = 2'd0,
        PRBS15 = 2'd1,
        PRBS23 = 2'd2,
        PRBS31 = 2'd3
    } poly_e;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } chk_state_e;

    // Selects the low N bits of the state that are live for a polynomial.
    function automatic logic [PRBS_MAX_N-1:0] poly_mask(input poly_e p);
        case (p)
            PRBS7:   return DEFAULT_SEED >> (PRBS_MAX_N - N_PRBS7);
            PRBS15:  return DEFAULT_SEED >> (PRBS_MAX_N - N_PRBS15);
            PRBS23:  return DEFAULT_SEED >> (PRBS_MAX_N - N_PRBS23);
            default: return DEFAULT_SEED >> (PRBS_MAX_N - N_PRBS31);
        endcase
    endfunction

endpackage

// File: rtl/prbs_step.sv
`timescale 1ns/1ps
// One word of LFSR advance: DATA_W serial steps unrolled combinationally.
// State bit k-1 holds r[k]; each step shifts left and inserts at bit 0.
module prbs_step
    import prbs_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [PRBS_MAX_N-1:0] state,
    input  poly_e                 poly,
    input  logic [DATA_W-1:0]     din,
    input  logic                  sync_mode,
    output logic [PRBS_MAX_N-1:0] next_state,
    output logic [DATA_W-1:0]     pred
);

    logic [PRBS_MAX_N-1:0] mask;
    logic [PRBS_MAX_N-1:0] s;
    logic                  fb;

    assign mask = poly_mask(poly);

    always_comb begin
        s    = state & mask;
        fb   = 1'b0;
        pred = '0;
        for (int i = 0; i < DATA_W; i++) begin
            case (poly)
                PRBS7:   fb = s[N_PRBS7-1]  ^ s[T_PRBS7-1];
                PRBS15:  fb = s[N_PRBS15-1] ^ s[T_PRBS15-1];
                PRBS23:  fb = s[N_PRBS23-1] ^ s[T_PRBS23-1];
                default: fb = s[N_PRBS31-1] ^ s[T_PRBS31-1];
            endcase
            pred[i] = fb;
            // Sync mode rebuilds the state from received bits instead of predictions.
            s = {s[PRBS_MAX_N-2:0], sync_mode ? din[i] : fb} & mask;
        end
        next_state = s;
    end

endmodule

// File: rtl/prbs_gen_chk.sv
`timescale 1ns/1ps
// PRBS7/15/23/31 parallel pattern generator plus self-synchronising checker
// with lock tracking and a saturating bit-error counter.
module prbs_gen_chk
    import prbs_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_CNT = 4,
    parameter int ERR_CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            poly_sel,
    input  logic                  gen_en,
    input  logic                  load,
    input  logic [PRBS_MAX_N-1:0] seed,
    input  logic                  inj_err,
    output logic [DATA_W-1:0]     tx_data,
    output logic                  tx_valid,
    input  logic [DATA_W-1:0]     rx_data,
    input  logic                  rx_valid,
    input  logic                  clr_cnt,
    output logic                  locked,
    output logic                  err_word,
    output logic [ERR_CNT_W-1:0]  err_cnt
);

    localparam int CW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(UNLOCK_CNT + 1);
    localparam int PW = $clog2(DATA_W + 1);
    localparam int SW = ((ERR_CNT_W > PW) ? ERR_CNT_W : PW) + 1;

    poly_e                 poly, poly_q;
    logic                  poly_chg;
    logic [PRBS_MAX_N-1:0] mask;

    assign poly     = poly_e'(poly_sel);
    assign poly_chg = (poly != poly_q);
    assign mask     = poly_mask(poly);

    // ---------------- generator ----------------
    logic [PRBS_MAX_N-1:0] gen_st, gen_cur, gen_nxt, seed_eff;
    logic [DATA_W-1:0]     gen_pred;
    logic                  inj_pend, inj_now;

    // A new polynomial may see an all-zero window of the old state; restart it.
    assign gen_cur  = (poly_chg && ((gen_st & mask) == '0)) ? mask : gen_st;
    assign seed_eff = ((seed & mask) == '0) ? mask : (seed & mask);
    assign inj_now  = inj_pend | inj_err;

    prbs_step #(.DATA_W(DATA_W)) u_gen (
        .state      (gen_cur),
        .poly       (poly),
        .din        ('0),
        .sync_mode  (1'b0),
        .next_state (gen_nxt),
        .pred       (gen_pred)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gen_st   <= DEFAULT_SEED;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            inj_pend <= 1'b0;
            poly_q   <= PRBS7;
        end else begin
            poly_q <= poly;
            if (load) begin
                gen_st   <= seed_eff;
                tx_valid <= 1'b0;
                inj_pend <= inj_now;
            end else if (gen_en) begin
                gen_st   <= gen_nxt;
                tx_data  <= gen_pred ^ DATA_W'(inj_now);
                tx_valid <= 1'b1;
                inj_pend <= 1'b0;
            end else begin
                gen_st   <= gen_cur;
                tx_valid <= 1'b0;
                inj_pend <= inj_now;
            end
        end
    end

    // ---------------- checker ----------------
    chk_state_e            cst, nst;
    logic [PRBS_MAX_N-1:0] chk_st, chk_nxt, st_nxt;
    logic [DATA_W-1:0]     chk_pred, e;
    logic [CW-1:0]         clean_cnt, clean_nxt;
    logic [BW-1:0]         bad_cnt, bad_nxt;
    logic [ERR_CNT_W-1:0]  cnt_nxt, cnt_sat;
    logic [PW-1:0]         pop;
    logic [SW-1:0]         sum;
    logic                  errw_nxt, chk_sync;

    assign chk_sync = (cst == SEARCH) || poly_chg;

    prbs_step #(.DATA_W(DATA_W)) u_chk (
        .state      (chk_st),
        .poly       (poly),
        .din        (rx_data),
        .sync_mode  (chk_sync),
        .next_state (chk_nxt),
        .pred       (chk_pred)
    );

    assign e = rx_data ^ chk_pred;

    always_comb begin
        pop = '0;
        for (int i = 0; i < DATA_W; i++)
            pop = pop + PW'(e[i]);
        sum     = SW'(err_cnt) + SW'(pop);
        cnt_sat = (sum > SW'({ERR_CNT_W{1'b1}})) ? '1 : ERR_CNT_W'(sum);
    end

    always_comb begin
        nst       = cst;
        st_nxt    = chk_st;
        clean_nxt = clean_cnt;
        bad_nxt   = bad_cnt;
        cnt_nxt   = err_cnt;
        errw_nxt  = 1'b0;
        if (poly_chg) begin
            nst       = SEARCH;
            clean_nxt = '0;
            bad_nxt   = '0;
            if (rx_valid)
                st_nxt = chk_nxt;
        end else if (rx_valid) begin
            st_nxt = chk_nxt;
            case (cst)
                SEARCH: begin
                    if (e != '0)
                        clean_nxt = '0;
                    else if (clean_cnt == CW'(LOCK_CNT - 1)) begin
                        nst       = LOCKED;
                        clean_nxt = '0;
                        bad_nxt   = '0;
                    end else
                        clean_nxt = clean_cnt + 1'b1;
                end
                default: begin
                    if (e != '0) begin
                        errw_nxt = 1'b1;
                        cnt_nxt  = cnt_sat;
                        if (bad_cnt == BW'(UNLOCK_CNT - 1)) begin
                            nst       = SEARCH;
                            clean_nxt = '0;
                            bad_nxt   = '0;
                        end else
                            bad_nxt = bad_cnt + 1'b1;
                    end else
                        bad_nxt = '0;
                end
            endcase
        end
        if (clr_cnt)
            cnt_nxt = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cst       <= SEARCH;
            chk_st    <= DEFAULT_SEED;
            clean_cnt <= '0;
            bad_cnt   <= '0;
            err_cnt   <= '0;
            err_word  <= 1'b0;
        end else begin
            cst       <= nst;
            chk_st    <= st_nxt;
            clean_cnt <= clean_nxt;
            bad_cnt   <= bad_nxt;
            err_cnt   <= cnt_nxt;
            err_word  <= errw_nxt;
        end
    end

    assign locked = (cst == LOCKED);

endmodule

// File: tb/tb_prbs_gen_chk.sv
`timescale 1ns/1ps
// Directed bench for prbs_gen_chk in loopback, with a serial LFSR reference.
module tb_prbs_gen_chk;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  poly_sel;
    logic        gen_en, load, inj_err, clr_cnt;
    logic [30:0] seed;
    logic [7:0]  tx_data, rx_data, flip;
    logic        tx_valid, rx_valid, locked, err_word;
    logic [3:0]  err_cnt;

    int total, bad, ew_cnt, words, mn, mt;
    logic [1:0]  m_poly;
    logic [31:1] mr;
    logic [7:0]  w;
    logic [7:0]  hist [3];

    always #5 clk = ~clk;

    assign rx_data  = tx_data ^ flip;
    assign rx_valid = tx_valid;

    prbs_gen_chk #(.DATA_W(8), .LOCK_CNT(16), .UNLOCK_CNT(4), .ERR_CNT_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .poly_sel (poly_sel),
        .gen_en   (gen_en),
        .load     (load),
        .seed     (seed),
        .inj_err  (inj_err),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .clr_cnt  (clr_cnt),
        .locked   (locked),
        .err_word (err_word),
        .err_cnt  (err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (err_word === 1'b1) ew_cnt++;
    endtask

    task automatic set_poly(input logic [1:0] p);
        m_poly = p;
        case (p)
            2'd0: begin mn = 7;  mt = 6;  end
            2'd1: begin mn = 15; mt = 14; end
            2'd2: begin mn = 23; mt = 18; end
            default: begin mn = 31; mt = 28; end
        endcase
    endtask

    task automatic model_word(output logic [7:0] mw);
        logic b;
        for (int i = 0; i < 8; i++) begin
            b     = mr[mn] ^ mr[mt];
            mw[i] = b;
            mr    = {mr[30:1], b};
        end
    endtask

    // Generate one word and compare it with the reference model.
    task automatic gen_word(input logic inj, output logic [7:0] mw);
        logic z;
        if (poly_sel != m_poly) begin
            set_poly(poly_sel);
            z = 1'b1;
            for (int i = 1; i <= mn; i++) if (mr[i]) z = 1'b0;
            if (z) for (int i = 1; i <= mn; i++) mr[i] = 1'b1;
        end
        inj_err = inj;
        gen_en  = 1'b1;
        tick();
        inj_err = 1'b0;
        model_word(mw);
        mw[0] = mw[0] ^ inj;
        chk("tx_word", {24'd0, tx_data}, {24'd0, mw});
    endtask

    initial begin
        total = 0; bad = 0; ew_cnt = 0; words = 0;
        reset = 1'b1; poly_sel = 2'd0; gen_en = 1'b0; load = 1'b0;
        inj_err = 1'b0; clr_cnt = 1'b0; seed = '0; flip = 8'h00;
        mr = '1; set_poly(2'd0);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_tx_data",  {24'd0, tx_data}, 32'h0);
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'h0);
        chk("rst_locked",   {31'd0, locked}, 32'h0);
        chk("rst_err_word", {31'd0, err_word}, 32'h0);
        chk("rst_err_cnt",  {28'd0, err_cnt}, 32'h0);
        reset = 1'b0;

        // PRBS7 from reset: hand-derived first words and period 127
        for (int k = 0; k < 130; k++) begin
            gen_word(1'b0, w);
            if (k < 3) hist[k] = w;
            if (k == 0) chk("p7_w0", {24'd0, tx_data}, 32'h40);
            if (k == 1) chk("p7_w1", {24'd0, tx_data}, 32'h30);
            if (k == 2) chk("p7_w2", {24'd0, tx_data}, 32'h14);
            if (k >= 127) chk("p7_period", {24'd0, tx_data}, {24'd0, hist[k-127]});
        end
        chk("p7_valid", {31'd0, tx_valid}, 32'h1);

        // Zero seed on PRBS15 becomes all-ones; load beats gen_en
        poly_sel = 2'd1; seed = '0; load = 1'b1; gen_en = 1'b1;
        tick();
        chk("load_wins_valid", {31'd0, tx_valid}, 32'h0);
        load = 1'b0; set_poly(2'd1); mr = '1;
        for (int k = 0; k < 20; k++) begin
            gen_word(1'b0, w);
            if (k == 0) chk("p15_w0", {24'd0, tx_data}, 32'h00);
            if (k == 1) chk("p15_w1", {24'd0, tx_data}, 32'h40);
        end

        // PRBS31 loopback lock time and clean long run
        poly_sel = 2'd3; seed = 31'h1234_5678; load = 1'b1;
        tick();
        chk("load31_valid", {31'd0, tx_valid}, 32'h0);
        load = 1'b0; set_poly(2'd3); mr = seed;
        words = 0;
        while (!locked && words < 25) begin
            if (rx_valid) words++;
            gen_word(1'b0, w);
        end
        chk("lock31", {31'd0, locked}, 32'h1);
        chk("lock31_time", {31'd0, (words <= 20)}, 32'h1);
        ew_cnt = 0;
        repeat (1000) gen_word(1'b0, w);
        chk("long_err_cnt", {28'd0, err_cnt}, 32'h0);
        chk("long_locked", {31'd0, locked}, 32'h1);
        chk("long_err_word", ew_cnt, 32'd0);

        // Single injected error
        ew_cnt = 0;
        gen_word(1'b1, w);
        repeat (3) gen_word(1'b0, w);
        chk("inj1_pulses", ew_cnt, 32'd1);
        chk("inj1_err_cnt", {28'd0, err_cnt}, 32'h1);
        chk("inj1_locked", {31'd0, locked}, 32'h1);

        // Four consecutive errored words drop lock, then 16 clean words relock
        repeat (4) gen_word(1'b1, w);
        chk("inj4_still_locked", {31'd0, locked}, 32'h1);
        gen_word(1'b0, w);
        chk("inj4_unlocked", {31'd0, locked}, 32'h0);
        chk("inj4_err_cnt", {28'd0, err_cnt}, 32'h5);
        words = 0;
        while (!locked && words < 40) begin
            if (rx_valid) words++;
            gen_word(1'b0, w);
        end
        chk("relock_words", words, 32'd16);

        // Saturation with inverted rx, then clear racing an error
        flip = 8'hFF;
        gen_word(1'b0, w);
        chk("sat_step", {28'd0, err_cnt}, 32'hD);
        gen_word(1'b0, w);
        chk("sat_full", {28'd0, err_cnt}, 32'hF);
        clr_cnt = 1'b1;
        gen_word(1'b0, w);
        clr_cnt = 1'b0;
        chk("clr_wins", {28'd0, err_cnt}, 32'h0);
        chk("sat_locked", {31'd0, locked}, 32'h1);
        flip = 8'h00;
        repeat (2) gen_word(1'b0, w);
        chk("clean_locked", {31'd0, locked}, 32'h1);

        // Switch PRBS31 -> PRBS7 while locked
        poly_sel = 2'd0;
        gen_word(1'b0, w);
        chk("polychg_unlock", {31'd0, locked}, 32'h0);
        words = 0;
        while (!locked && words < 30) begin
            if (rx_valid) words++;
            gen_word(1'b0, w);
        end
        chk("p7_relock", {31'd0, locked}, 32'h1);
        chk("p7_relock_time", {31'd0, (words <= 17)}, 32'h1);

        // Asynchronous reset mid-stream
        gen_word(1'b1, w);
        repeat (2) gen_word(1'b0, w);
        chk("pre_rst_err_cnt", {28'd0, err_cnt}, 32'h1);
        reset = 1'b1;
        #2;
        chk("arst_tx_data",  {24'd0, tx_data}, 32'h0);
        chk("arst_tx_valid", {31'd0, tx_valid}, 32'h0);
        chk("arst_locked",   {31'd0, locked}, 32'h0);
        chk("arst_err_word", {31'd0, err_word}, 32'h0);
        chk("arst_err_cnt",  {28'd0, err_cnt}, 32'h0);
        gen_en = 1'b0;
        tick();
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prbs_gen_chk.md
Name: prbs_gen_chk

Overview:
Parametrised multi-polynomial PRBS block with a parallel pattern generator and a self-synchronising pattern checker. Pattern length is selectable at run time: PRBS7, PRBS15, PRBS23 or PRBS31. It processes DATA_W bits per clock. Used for link BIST: the generator drives the TX datapath, and the checker monitors RX, reports lock and counts bit errors.

Parameters:
DATA_W, 8, bits generated/checked per clock (1..32)
LOCK_CNT, 16, consecutive error-free rx words needed to declare lock
UNLOCK_CNT, 4, consecutive errored rx words needed to drop lock
ERR_CNT_W, 16, width of saturating bit-error counter

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
poly_sel  in  2  polynomial select: 0=x^7+x^6+1, 1=x^15+x^14+1, 2=x^23+x^18+1, 3=x^31+x^28+1
gen_en  in  1  advance generator one word
load  in  1  load generator state from seed
seed  in  31  generator seed; low N bits used for the selected polynomial
inj_err  in  1  invert bit 0 of the next generated word
tx_data  out  DATA_W  generated word; bit 0 is the earliest serial bit
tx_valid  out  1  tx_data valid
rx_data  in  DATA_W  received word; bit 0 is the earliest bit
rx_valid  in  1  rx_data valid
clr_cnt  in  1  synchronous clear of err_cnt
locked  out  1  checker locked
err_word  out  1  one-cycle pulse: last checked word had at least one bit error while locked
err_cnt  out  ERR_CNT_W  saturating bit-error count

Behaviour:
- LFSR convention: state bits r[1..N]; fb = r[N]^r[T] (T = 6/14/18/28); next state = {fb, r[1..N-1]}; output bit = fb. One word = DATA_W serial steps unrolled in one cycle.
- Reset: generator state = all-ones (low N bits), tx_data=0, tx_valid=0, locked=0, err_word=0, err_cnt=0, checker state = all-ones, FSM = SEARCH.
- Generator priority is load > gen_en.
  - load: state <= seed[N-1:0]; an all-zero seed is replaced by all-ones (lockup prevention); tx_valid=0 that cycle.
  - gen_en: tx_data <= next DATA_W bits, registered (one-cycle latency); tx_valid <= 1; state advances DATA_W steps.
  - gen_en=0: tx_valid <= 0, state held.
- inj_err: latched sticky until the next generated word, then tx_data[0] is inverted in that word only; the LFSR state is not affected.
- Checker per rx_valid word: for each bit i, pred_i = fb(state); e_i = rx_i ^ pred_i.
  - In SEARCH, state shifts in the received bit rx_i (self-synchronising).
  - In LOCKED, state shifts in pred_i (free-running).
  - rx_valid=0: nothing changes, and counters do not advance.
- FSM SEARCH: an error-free word increments clean_cnt, any error resets it to 0. clean_cnt reaching LOCK_CNT -> LOCKED, locked=1 next cycle, bad_cnt=0.
- FSM LOCKED: an errored word sets err_word for 1 cycle, increments bad_cnt, and adds popcount(e) to err_cnt. A clean word resets bad_cnt. bad_cnt reaching UNLOCK_CNT -> SEARCH, locked=0, clean_cnt=0.
- Lock time: from a clean stream, locked rises within LOCK_CNT + ceil(N/DATA_W) valid words.
- err_cnt: saturates at all-ones and never wraps. Accumulates only in LOCKED. If clr_cnt and an error occur in the same cycle, clr_cnt wins (err_cnt=0).
- poly_sel change (any cycle it differs from the previous value):
  - checker forced to SEARCH, clean_cnt=0, locked=0 next cycle;
  - generator continues from its current low N bits; if those are all-zero it reloads all-ones.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); no partial word is output.

Decomposition:
- Package prbs_pkg holds:
  - poly_e enum (PRBS7/15/23/31);
  - tap-length and tap-position constants per poly;
  - PRBS_MAX_N=31;
  - DEFAULT_SEED = 31'h7FFF_FFFF;
  - checker state enum (SEARCH, LOCKED).
- Sub-module prbs_step (combinational): inputs state[31], poly, din[DATA_W], sync_mode; outputs next_state, pred[DATA_W]. The generator uses sync_mode=0 with din ignored. It is instantiated once for the generator and once for the checker.

Test Plan:
- Reset, poly_sel=0, DATA_W=8, gen_en=1 -> first tx_data = 8'h40 one cycle later; word k+127 equals word k.
- load with seed=0, poly_sel=1 -> state becomes 15'h7FFF; the stream is identical to the post-reset PRBS15 stream; load and gen_en together -> load wins, tx_valid=0.
- tx_data looped to rx_data, poly_sel=3 -> locked=1 within 20 valid words; err_cnt stays 0 for 1000 words.
- Locked, single inj_err pulse -> one err_word pulse, err_cnt=1, locked stays 1; 4 consecutive inj_err words -> locked=0 after the 4th, then relocks after 16 clean words.
- ERR_CNT_W=4, rx inverted while locked -> err_cnt saturates at 4'hF; clr_cnt in the same cycle as an error -> err_cnt=0.
- poly_sel switched 3->0 while locked -> locked=0 next cycle, relock on PRBS7 within 17 words; reset asserted mid-stream -> all outputs 0 immediately.
